hex_scroll_monitor: RTL
=======================

HEX_SCROLL_MONITOR -- requirements
Module: hex_scroll_monitor

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 30000000, meaning CLOCK_50 cycles without frame_tick before stall is declared (used only with SCROLL_TIMEOUT_EN).
REQ-002 SHALL have port CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port SW  input  1  SW[0] is the reset, asynchronous and active-high.
REQ-004 SHALL have ports HEX0, HEX1, HEX2, HEX3  input  7 each  active-low segment patterns of the watched scroller display, with HEX0 the rightmost digit.
REQ-005 SHALL have port frame_tick  input  1  single-cycle strobe marking one display update.
REQ-006 SHALL have port char_code  output  16  registered decoded frame, with HEX3 in [15:12] and HEX0 in [3:0].
REQ-007 SHALL have port frame_idx  output  3  registered index (0..7) of the last matched frame.
REQ-008 SHALL have port locked  output  1  monitor is tracking the scroll sequence.
REQ-009 SHALL have port err_cnt  output  8  saturating mismatch counter.
REQ-010 SHALL have port bad_glyph  output  1  last sampled frame contained an undecodable pattern.
REQ-011 SHALL have port stall  output  1  frame_tick timeout flag; constant 0 when the feature is compiled out.

Function
REQ-012 SHALL decode each digit as follows: 1111111 -> 0x0 (blank), 0001110 -> 0x1 (F), 0001100 -> 0x2 (P), 0000010 -> 0x3 (G), 0001000 -> 0x4 (A), any other pattern -> 0xF.
REQ-013 SHALL use the frame table, index -> char_code: 0 -> 0x1234, 1 -> 0x0123, 2 -> 0x0012, 3 -> 0x0001, 4 -> 0x0000, 5 -> 0x4000, 6 -> 0x3400, 7 -> 0x2340.
REQ-014 SHALL sample the HEX inputs only on cycles where frame_tick=1, and update char_code and bad_glyph on the following clock edge (1-cycle latency).
REQ-015 SHALL implement FSM states HUNT, SYNC and LOCK, evaluated once per sampled frame; states SHALL NOT change on cycles without a tick.
REQ-016 In HUNT, a frame matching a non-blank table entry k SHALL load pred=(k+1) mod 8, set frame_idx=k and go to SYNC; a blank or unmatched frame SHALL stay in HUNT, because blank is ambiguous with the start frame.
REQ-017 In SYNC, a frame equal to table[pred] SHALL set frame_idx=pred, advance pred, go to LOCK and set locked=1; otherwise the FSM SHALL increment err_cnt and go to HUNT.
REQ-018 In LOCK, a match SHALL advance frame_idx and pred, wrapping 7 -> 0; a mismatch SHALL increment err_cnt, clear locked and go to HUNT.
REQ-019 A frame containing any 0xF digit SHALL set bad_glyph=1 and count as a mismatch in SYNC and LOCK.
REQ-020 err_cnt SHALL saturate at 255.
REQ-021 locked SHALL be 1 only in the LOCK state.

Reset
REQ-022 While SW[0]=1, the block SHALL hold state=HUNT, char_code=0x0000, frame_idx=0, locked=0, err_cnt=0, bad_glyph=0, stall=0 and the timeout counter at 0, with immediate effect regardless of the clock.
REQ-023 Reset asserted mid-sequence SHALL discard the prediction; after release, the block SHALL require two consecutive matching frames to relock.

Configuration
REQ-024 With SCROLL_TIMEOUT_EN defined, the block SHALL count cycles since the last frame_tick; on reaching TIMEOUT_CYC it SHALL set stall=1, force HUNT and clear locked, and the next frame_tick SHALL clear stall and the counter.
REQ-025 Without SCROLL_TIMEOUT_EN, the block SHALL omit the counter and tie stall to 0.

Structure
REQ-026 Package scroll_pkg SHALL hold the character codes, the 8-entry frame table, the FSM state enum and the segment pattern constants.
REQ-027 A combinational sub-module seg7_to_char (7-bit pattern in, 4-bit code out) SHALL be instantiated four times.

Verification
REQ-028 Reset, then ticked frames 0x1234, 0x0123, 0x0012 -> locked=1 one cycle after the second tick, frame_idx=2, err_cnt=0.
REQ-029 Locked, frames 0x2340 then 0x1234 -> frame_idx wraps 7 -> 0, locked stays 1.
REQ-030 Locked at idx 2, frame 0x0123 injected -> err_cnt=1, locked=0, FSM in HUNT.
REQ-031 HEX2=0000000 on a tick -> bad_glyph=1, char_code[11:8]=0xF.
REQ-032 Blank frames repeated from reset -> FSM remains in HUNT and err_cnt=0; pulsing SW[0] while locked drops locked within the same cycle.
REQ-033 With SCROLL_TIMEOUT_EN and TIMEOUT_CYC=100: locked, then no tick for 100 cycles -> stall=1, locked=0; the next tick clears stall.

Source files
------------

// File: rtl/scroll_pkg.sv
// Shared definitions for the scroller monitor: glyph codes, segment patterns,
// the expected 8-frame scroll table and the tracking FSM state encoding.
// Pure declarations; no state, no latency, no flow control.
package scroll_pkg;

  // Tracking FSM states
  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } state_t;

  // Decoded character codes
  localparam logic [3:0] CH_BLANK = 4'h0;
  localparam logic [3:0] CH_F     = 4'h1;
  localparam logic [3:0] CH_P     = 4'h2;
  localparam logic [3:0] CH_G     = 4'h3;
  localparam logic [3:0] CH_A     = 4'h4;
  localparam logic [3:0] CH_BAD   = 4'hF;

  // Active-low segment patterns (bit 6 = segment g, bit 0 = segment a)
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_G     = 7'b0000010;
  localparam logic [6:0] SEG_A     = 7'b0001000;

  // Scroll sequence, entry 0 in the low 16 bits.
  // Entry 4 is the all-blank frame and cannot anchor a lock.
  localparam int          NUM_FRAMES  = 8;
  localparam int          BLANK_FRAME = 4;
  localparam logic [7:0][15:0] FRAME_TABLE = {
    16'h2340,  // 7
    16'h3400,  // 6
    16'h4000,  // 5
    16'h0000,  // 4
    16'h0001,  // 3
    16'h0012,  // 2
    16'h0123,  // 1
    16'h1234   // 0
  };

  // True when any digit of a decoded frame is the undecodable code
  function automatic logic frame_has_bad(input logic [15:0] frame);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (frame[i*4 +: 4] == CH_BAD) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/seg7_to_char.sv
// Decodes one active-low 7-segment pattern into a 4-bit character code.
// Latency: purely combinational.
// Backpressure: none.
module seg7_to_char
  import scroll_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code
);

  // Map the five known glyphs; anything else is flagged as undecodable
  always_comb begin
    code = CH_BAD;
    case (seg)
      SEG_BLANK: code = CH_BLANK;
      SEG_F:     code = CH_F;
      SEG_P:     code = CH_P;
      SEG_G:     code = CH_G;
      SEG_A:     code = CH_A;
      default:   code = CH_BAD;
    endcase
  end

endmodule

// File: rtl/hex_scroll_monitor.sv
// Watches a 4-digit scrolling display and tracks its position in the 8-frame sequence.
// Latency: outputs update on the clock edge that samples frame_tick (1 cycle).
// Backpressure: none; optional SCROLL_TIMEOUT_EN adds a frame_tick stall watchdog.
module hex_scroll_monitor
  import scroll_pkg::*;
#(
  parameter int TIMEOUT_CYC = 30000000
) (
  input  logic        CLOCK_50,
  input  logic [0:0]  SW,
  input  logic [6:0]  HEX0,
  input  logic [6:0]  HEX1,
  input  logic [6:0]  HEX2,
  input  logic [6:0]  HEX3,
  input  logic        frame_tick,
  output logic [15:0] char_code,
  output logic [2:0]  frame_idx,
  output logic        locked,
  output logic [7:0]  err_cnt,
  output logic        bad_glyph,
  output logic        stall
);

  logic        rst;
  logic [15:0] frame;
  logic        has_bad;
  logic        hunt_hit;
  logic [2:0]  hunt_k;
  logic        pred_match;
  logic        timeout_fire;

  state_t      state, state_n;
  logic [2:0]  pred, pred_n;
  logic [2:0]  idx_n;
  logic        err_inc;

  assign rst = SW[0];

  seg7_to_char u_dec0 (.seg(HEX0), .code(frame[3:0]));
  seg7_to_char u_dec1 (.seg(HEX1), .code(frame[7:4]));
  seg7_to_char u_dec2 (.seg(HEX2), .code(frame[11:8]));
  seg7_to_char u_dec3 (.seg(HEX3), .code(frame[15:12]));

  assign has_bad    = frame_has_bad(frame);
  assign pred_match = !has_bad && (frame == FRAME_TABLE[pred]);

  // Find which non-blank table entry the current frame matches, if any
  always_comb begin
    hunt_hit = 1'b0;
    hunt_k   = 3'd0;
    for (int k = 0; k < NUM_FRAMES; k++) begin
      if (k != BLANK_FRAME && frame == FRAME_TABLE[k]) begin
        hunt_hit = 1'b1;
        hunt_k   = 3'(k);
      end
    end
  end

`ifdef SCROLL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] idle_cnt;

  // Fires once, on the cycle the idle count reaches TIMEOUT_CYC
  assign timeout_fire = !frame_tick && (idle_cnt == CW'(TIMEOUT_CYC - 1));

  // Idle-cycle counter; holds at TIMEOUT_CYC until the next tick
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
      stall    <= 1'b0;
    end else if (frame_tick) begin
      idle_cnt <= '0;
      stall    <= 1'b0;
    end else if (idle_cnt != CW'(TIMEOUT_CYC)) begin
      idle_cnt <= idle_cnt + 1'b1;
      if (timeout_fire) stall <= 1'b1;
    end
  end
`else
  assign timeout_fire = 1'b0;
  // No watchdog: stall is constant 0 (parameter referenced only to keep the interface uniform)
  assign stall = 1'b0 & (TIMEOUT_CYC == 0);
`endif

  // Next-state logic: the FSM only moves on sampled frames or a watchdog expiry
  always_comb begin
    state_n = state;
    pred_n  = pred;
    idx_n   = frame_idx;
    err_inc = 1'b0;
    if (frame_tick) begin
      case (state)
        HUNT: begin
          if (hunt_hit) begin
            state_n = SYNC;
            idx_n   = hunt_k;
            pred_n  = hunt_k + 3'd1;
          end
        end
        SYNC, LOCK: begin
          if (pred_match) begin
            state_n = LOCK;
            idx_n   = pred;
            pred_n  = pred + 3'd1;
          end else begin
            state_n = HUNT;
            err_inc = 1'b1;
          end
        end
        default: state_n = HUNT;
      endcase
    end
    if (timeout_fire) state_n = HUNT;
  end

  // FSM, prediction, index and saturating error counter registers
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      pred      <= 3'd0;
      frame_idx <= 3'd0;
      err_cnt   <= 8'd0;
    end else begin
      state     <= state_n;
      pred      <= pred_n;
      frame_idx <= idx_n;
      if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  // Capture the decoded frame and its glyph-validity flag on each tick
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      char_code <= 16'h0000;
      bad_glyph <= 1'b0;
    end else if (frame_tick) begin
      char_code <= frame;
      bad_glyph <= has_bad;
    end
  end

  assign locked = (state == LOCK);

endmodule
